tone_wave_gen: RTL and testbench
================================

// Module: tone_wave_gen
// PURPOSE
//  Downstream consumer of the tone LUT's 16-bit sixteenth_period (100 MHz cycles per 1/16 waveform).
//  Accepts one note per valid/ready handshake and steps a 16-entry waveform table once per sixteenth_period.
//  Plays the note for a programmed number of whole waveform cycles, then pulses done.
//  Drives a 1-bit PWM audio output that feeds the board's audio filter pin.
// PARAMETERS
//  REST_PERIOD  16'd23889  step time used when sixteenth_period==0 (rest / undefined tone); output held silent
//  ENV_CYCLES   8'd16      waveform cycles per envelope decrement (used only with TONE_ENVELOPE_EN)
// PORTS
//  clk               in   1   100 MHz system clock
//  rst_n             in   1   asynchronous active-low reset
//  sixteenth_period  in   16  cycles per waveform step, from the tone LUT; 0 = rest
//  note_cycles       in   8   whole waveform cycles to play; 0 is treated as 1
//  wave_sel          in   1   0 = square, 1 = triangle
//  volume            in   4   amplitude scale 0..15
//  note_valid        in   1   note fields valid
//  note_ready        out  1   block can accept a note
//  stop              in   1   abort current note
//  busy              out  1   high while state==PLAY
//  done              out  1   one-cycle pulse when a note completes normally
//  step              out  4   current waveform step index
//  pwm_out           out  1   PWM audio output
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every counter=0; step=0; pwm_out=0; done=0; busy=0.
//   note_ready is combinational and reads 1 out of reset.
//  States: IDLE, PLAY.
//  note_ready = (state==IDLE) && !stop.
//  Accept when note_valid && note_ready at edge T. Latch period, cycles, wave_sel and volume.
//   At T+1: state=PLAY, busy=1, step=0, per_cnt=0, cyc_cnt=0.
//  Latched period p==0 -> p_eff=REST_PERIOD and pwm_out is forced to 0; otherwise p_eff=p.
//  PLAY timing:
//   per_cnt counts 0..p_eff-1. At p_eff-1 it wraps to 0 and step increments (15 wraps to 0).
//   p_eff==1 advances step every cycle.
//   On a step 15->0 wrap, cyc_cnt increments.
//   If that wrap completes cycle number N (N = latched note_cycles, 0 treated as 1):
//    next state=IDLE; done=1 for exactly 1 cycle; step returns to 0.
//  stop=1 in PLAY: next cycle IDLE, busy=0, pwm_out=0, no done pulse.
//  stop=1 in IDLE: no note is accepted (stop wins over note_valid).
//  Note fields are ignored outside the accepting edge; input changes during PLAY have no effect.
//  Wave table (8-bit):
//   square: steps 0-7 = 255, steps 8-15 = 0.
//   triangle: k<8 -> 32k+31; k>=8 -> 32(15-k)+31.
//  amp = (table[step] * vol_eff) >> 4, giving an 8-bit result (max 239).
//  PWM: 8-bit free-running pwm_cnt in all states. pwm_out is registered: (pwm_cnt < amp) && PLAY && p!=0.
//   Latency: one cycle from a step/amp change to pwm_out.
//  vol_eff = latched volume (without envelope).
// CONFIGURATION
//  TONE_ENVELOPE_EN defined:
//   vol_eff loads the latched volume on accept.
//   vol_eff decrements by 1 every ENV_CYCLES completed waveform cycles and saturates at 0.
//   The note still runs to N cycles.
//  TONE_ENVELOPE_EN undefined: vol_eff is constant; no envelope counter is synthesized.
// STRUCTURE
//  Package tone_pkg: state enum {IDLE, PLAY}; WAVE_SQUARE=0 and WAVE_TRI=1;
//   16x8 wave table constants; REST_PERIOD default.
//  Sub-module tone_pwm: input amp[7:0], output pwm_out; owns pwm_cnt and the output register.
//  Top holds the FSM, period/step/cycle counters and amp scaling.
// TESTING
//  1. Reset with rst_n=0 mid-PLAY -> pwm_out=0, busy=0, step=0 immediately;
//     note_ready=1 once rst_n=1 and stop=0.
//  2. Note p=4, cycles=2, square, vol=15 -> step advances every 4 clks;
//     done pulses once 128 clks after PLAY entry; busy falls with done.
//  3. Square vol=15 at step 0 -> amp=239; pwm_out high for 239 of 256 clks; step 8 -> pwm_out stays 0.
//  4. p=0, cycles=1 -> pwm_out stays 0; done after 16*REST_PERIOD clks.
//  5. stop at clk 10 of PLAY -> IDLE next clk, no done pulse.
//     note_valid held with stop=1 in IDLE -> not accepted.
//  6. p=1, cycles=0, triangle, vol=8 -> step increments every clk;
//     done after 16 clks; step 7 amp = 127.

Source files
------------

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types, wave tables and defaults for the tone wave generator
package tone_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } tone_state_t;

    localparam logic WAVE_SQUARE = 1'b0;
    localparam logic WAVE_TRI    = 1'b1;

    localparam logic [15:0] REST_PERIOD_DEF = 16'd23889;
    localparam logic [7:0]  ENV_CYCLES_DEF  = 8'd16;

    // Packed tables: element [k] is the sample for step k (index 15 written first).
    localparam logic [15:0][7:0] SQUARE_TABLE = {{8{8'd0}}, {8{8'd255}}};
    localparam logic [15:0][7:0] TRI_TABLE = {
        8'd31,  8'd63,  8'd95,  8'd127, 8'd159, 8'd191, 8'd223, 8'd255,
        8'd255, 8'd223, 8'd191, 8'd159, 8'd127, 8'd95,  8'd63,  8'd31
    };

    function automatic logic [7:0] wave_sample(input logic sel, input logic [3:0] k);
        return (sel == WAVE_TRI) ? TRI_TABLE[k] : SQUARE_TABLE[k];
    endfunction

endpackage

// File: rtl/tone_pwm.sv
// rtl/tone_pwm.sv - free-running 8-bit PWM with registered output
module tone_pwm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] amp,
    output logic       pwm_out
);

    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_out <= (pwm_cnt < amp);
        end
    end

endmodule

// File: rtl/tone_wave_gen.sv
// rtl/tone_wave_gen.sv - note player stepping a 16-entry wave table into PWM; optional TONE_ENVELOPE_EN volume decay
module tone_wave_gen
    import tone_pkg::*;
#(
    parameter logic [15:0] REST_PERIOD = REST_PERIOD_DEF
`ifdef TONE_ENVELOPE_EN
    ,
    parameter logic [7:0]  ENV_CYCLES  = ENV_CYCLES_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sixteenth_period,
    input  logic [7:0]  note_cycles,
    input  logic        wave_sel,
    input  logic [3:0]  volume,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic [3:0]  step,
    output logic        pwm_out
);

    tone_state_t state, state_next;

    logic [15:0] lat_period;
    logic [7:0]  lat_cycles;
    logic        lat_wave;
    logic [3:0]  lat_vol;
    logic [15:0] per_cnt;
    logic [7:0]  cyc_cnt;
    logic [3:0]  vol_eff;
    logic [7:0]  amp;
    logic [7:0]  amp_gated;

    logic [15:0] p_eff;
    logic [7:0]  n_eff;
    logic        accept, step_wrap, cycle_wrap, last_cycle;

    assign note_ready = (state == IDLE) && !stop;
    assign busy       = (state == PLAY);
    assign accept     = note_valid && note_ready;

    assign p_eff      = (lat_period == 16'd0) ? REST_PERIOD : lat_period;
    assign n_eff      = (lat_cycles == 8'd0) ? 8'd1 : lat_cycles;
    assign step_wrap  = (state == PLAY) && (per_cnt == p_eff - 16'd1);
    assign cycle_wrap = step_wrap && (step == 4'd15);
    assign last_cycle = cycle_wrap && (cyc_cnt + 8'd1 == n_eff);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = PLAY;
            PLAY: if (stop || last_cycle) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_period <= 16'd0;
            lat_cycles <= 8'd0;
            lat_wave   <= 1'b0;
            lat_vol    <= 4'd0;
            per_cnt    <= 16'd0;
            cyc_cnt    <= 8'd0;
            step       <= 4'd0;
            done       <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (accept) begin
                lat_period <= sixteenth_period;
                lat_cycles <= note_cycles;
                lat_wave   <= wave_sel;
                lat_vol    <= volume;
                per_cnt    <= 16'd0;
                cyc_cnt    <= 8'd0;
                step       <= 4'd0;
            end else if (state == PLAY) begin
                if (stop) begin
                    per_cnt <= 16'd0;
                    cyc_cnt <= 8'd0;
                    step    <= 4'd0;
                end else if (step_wrap) begin
                    per_cnt <= 16'd0;
                    step    <= step + 4'd1;
                    if (cycle_wrap) begin
                        cyc_cnt <= last_cycle ? 8'd0 : cyc_cnt + 8'd1;
                        done    <= last_cycle;
                    end
                end else begin
                    per_cnt <= per_cnt + 16'd1;
                end
            end
        end
    end

`ifdef TONE_ENVELOPE_EN
    logic [7:0] env_cnt;

    // Volume drops one notch per ENV_CYCLES completed waveform cycles, floor at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_eff <= 4'd0;
            env_cnt <= 8'd0;
        end else if (accept) begin
            vol_eff <= volume;
            env_cnt <= 8'd0;
        end else if (cycle_wrap && !stop) begin
            if (env_cnt == ENV_CYCLES - 8'd1) begin
                env_cnt <= 8'd0;
                if (vol_eff != 4'd0) vol_eff <= vol_eff - 4'd1;
            end else begin
                env_cnt <= env_cnt + 8'd1;
            end
        end
    end
`else
    assign vol_eff = lat_vol;
`endif

    assign amp = 8'(({4'd0, wave_sample(lat_wave, step)} * {8'd0, vol_eff}) >> 4);

    // Gate on stop too so pwm_out is already low in the first IDLE cycle after an abort.
    assign amp_gated = ((state == PLAY) && !stop && (lat_period != 16'd0)) ? amp : 8'd0;

    tone_pwm u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .amp     (amp_gated),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_tone_wave_gen.sv
// tb/tb_tone_wave_gen.sv - directed self-checking bench for tone_wave_gen
module tb_tone_wave_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sixteenth_period;
    logic [7:0]  note_cycles;
    logic        wave_sel;
    logic [3:0]  volume;
    logic        note_valid;
    logic        note_ready;
    logic        stop;
    logic        busy;
    logic        done;
    logic [3:0]  step;
    logic        pwm_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tone_wave_gen #(.REST_PERIOD(16'd20)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sixteenth_period (sixteenth_period),
        .note_cycles      (note_cycles),
        .wave_sel         (wave_sel),
        .volume           (volume),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .stop             (stop),
        .busy             (busy),
        .done             (done),
        .step             (step),
        .pwm_out          (pwm_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a note for one edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] p, input logic [7:0] n, input logic w, input logic [3:0] v);
        sixteenth_period = p;
        note_cycles      = n;
        wave_sel         = w;
        volume           = v;
        note_valid       = 1'b1;
        tick(1);
        note_valid       = 1'b0;
    endtask

    initial begin
        int highs;
        int pulses;
        int waited;

        rst_n = 1'b0;
        sixteenth_period = 16'd0;
        note_cycles = 8'd0;
        wave_sel = 1'b0;
        volume = 4'd0;
        note_valid = 1'b0;
        stop = 1'b0;
        #12;
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_ready", 32'(note_ready), 1);
        rst_n = 1'b1;
        tick(2);

        // p=4, 2 cycles, square: step every 4 clks, done 128 clks after entry
        send(16'd4, 8'd2, 1'b0, 4'd15);
        chk("t2_busy_entry", 32'(busy), 1);
        chk("t2_step_entry", 32'(step), 0);
        tick(3);
        chk("t2_step_hold", 32'(step), 0);
        tick(1);
        chk("t2_step1", 32'(step), 1);
        tick(4);
        chk("t2_step2", 32'(step), 2);
        pulses = 0;
        for (int i = 0; i < 119; i++) begin
            tick(1);
            pulses += int'(done);
        end
        chk("t2_no_early_done", 32'(pulses), 0);
        chk("t2_busy_127", 32'(busy), 1);
        tick(1);
        chk("t2_done", 32'(done), 1);
        chk("t2_busy_fall", 32'(busy), 0);
        chk("t2_step_back", 32'(step), 0);
        tick(1);
        chk("t2_done_pulse", 32'(done), 0);

        // square vol=15: 239/256 duty at step 0, silent at step 8
        send(16'd300, 8'd1, 1'b0, 4'd15);
        chk("t3_amp239", 32'(dut.amp), 239);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            highs += int'(pwm_out);
        end
        chk("t3_duty", 32'(highs), 239);
        tick(2144);
        chk("t3_step8", 32'(step), 8);
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            highs += int'(pwm_out);
        end
        chk("t3_step8_silent", 32'(highs), 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t3_stopped", 32'(busy), 0);

        // stop at clk 10 of PLAY, then stop blocks acceptance
        send(16'd4, 8'd2, 1'b0, 4'd15);
        tick(9);
        stop = 1'b1;
        tick(1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_no_done", 32'(done), 0);
        chk("t5_pwm", 32'(pwm_out), 0);
        note_valid = 1'b1;
        #1;
        chk("t5_ready_low", 32'(note_ready), 0);
        tick(3);
        chk("t5_not_accepted", 32'(busy), 0);
        note_valid = 1'b0;
        stop = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            pulses += int'(done);
        end
        chk("t5_no_late_done", 32'(pulses), 0);

        // rest note: silent, done after 16*REST_PERIOD (=320) clks
        send(16'd0, 8'd1, 1'b0, 4'd15);
        highs = 0;
        pulses = 0;
        for (int i = 0; i < 319; i++) begin
            tick(1);
            highs += int'(pwm_out);
            pulses += int'(done);
        end
        chk("t4_silent", 32'(highs), 0);
        chk("t4_no_early_done", 32'(pulses), 0);
        tick(1);
        chk("t4_done", 32'(done), 1);

        // p=1, cycles=0 (as 1), triangle vol=8
        send(16'd1, 8'd0, 1'b1, 4'd8);
        chk("t6_step0", 32'(step), 0);
        tick(7);
        chk("t6_step7", 32'(step), 7);
        chk("t6_amp127", 32'(dut.amp), 127);
        tick(8);
        chk("t6_step15", 32'(step), 15);
        chk("t6_no_done", 32'(done), 0);
        tick(1);
        chk("t6_done", 32'(done), 1);
        chk("t6_step_back", 32'(step), 0);

        // async reset mid-PLAY while pwm_out is high
        send(16'd4, 8'd3, 1'b0, 4'd15);
        tick(9);
        waited = 0;
        while (pwm_out !== 1'b1 && waited < 12) begin
            tick(1);
            waited++;
        end
        chk("t1_pwm_high_before", 32'(pwm_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_pwm", 32'(pwm_out), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_step", 32'(step), 0);
        #3 rst_n = 1'b1;
        tick(1);
        chk("t1_ready", 32'(note_ready), 1);
        chk("t1_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
